// File: rtl/sha256_pkg.sv
// Shared SHA-256 sequencing definitions: round geometry and the controller FSM encoding.
// Used by the round controller, message schedule and top-level sequencer.
package sha256_pkg;

    localparam int ROUNDS        = 64;
    localparam int CNT_W         = 6;
    localparam int W_LOAD_ROUNDS = 16;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Rounds 0..15 take W straight from the message block; later rounds use the expansion.
    function automatic logic is_load_round(input logic [CNT_W-1:0] cnt);
        return cnt < CNT_W'(W_LOAD_ROUNDS);
    endfunction

endpackage

// File: rtl/sha256_round_counter.sv
// Round counter for the SHA-256 controller: clear/enable/hold, last-round flag and
// the look-ahead address cnt+1 used to prefetch the next K constant.
module sha256_round_counter
    import sha256_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_hold,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_next,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !i_hold && !o_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_next = r_cnt + 1'b1;
    assign o_last     = (r_cnt == LAST_CNT);

endmodule

// File: rtl/sha256_round_controller.sv
// SHA-256 compression round controller: start handshake, 64-round sequencing, K address look-ahead.
// Optional round stall input 'hold' is present when SHA256_CTRL_STALL_EN is defined.
module sha256_round_controller
    import sha256_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             first_block,
    output logic             ready,
    output logic             busy,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] cur_round,
    output logic             round_en,
    output logic             w_load,
    output logic             init_hash,
    output logic             final_add,
    output logic             done
`ifdef SHA256_CTRL_STALL_EN
    ,
    input  logic             hold
`endif
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_first;
    logic             w_hold;
    logic             w_stall;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_next;

`ifdef SHA256_CTRL_STALL_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    // Hold only freezes the round phase; handshake and final/done phases run regardless.
    assign w_stall = w_hold && (r_state == ST_PRIME || r_state == ST_ROUND);

    sha256_round_counter u_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (r_state != ST_ROUND && r_state != ST_PRIME),
        .i_enable   (r_state == ST_ROUND),
        .i_hold     (w_stall),
        .o_cnt      (w_cnt),
        .o_cnt_next (w_cnt_next),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && start) begin
                r_first <= first_block;
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        round        = '0;
        round_en     = 1'b0;
        init_hash    = 1'b0;
        final_add    = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_PRIME;
            end
            ST_PRIME: begin
                init_hash = r_first && !w_stall;
                if (!w_stall) w_state_next = ST_ROUND;
            end
            ST_ROUND: begin
                // While stalled, re-address K[cnt] so k_out is correct on the resumed round.
                round    = w_stall ? w_cnt : w_cnt_next;
                round_en = !w_stall;
                if (!w_stall && w_last) w_state_next = ST_FINAL;
            end
            ST_FINAL: begin
                final_add    = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign ready     = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign cur_round = w_cnt;
    assign w_load    = round_en && is_load_round(w_cnt);

endmodule

// File: tb/tb_sha256_round_controller.sv
// Directed self-checking bench for sha256_round_controller with a registered K-table model.
// Stall scenarios run only when SHA256_CTRL_STALL_EN is defined.
module tb_sha256_round_controller;
    import sha256_pkg::*;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             first_block;
    logic             hold;
    logic             ready;
    logic             busy;
    logic [CNT_W-1:0] round;
    logic [CNT_W-1:0] cur_round;
    logic             round_en;
    logic             w_load;
    logic             init_hash;
    logic             final_add;
    logic             done;
    logic [31:0]      k_out;

    int n_cmp = 0;
    int n_bad = 0;

    sha256_round_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .first_block (first_block),
        .ready       (ready),
        .busy        (busy),
        .round       (round),
        .cur_round   (cur_round),
        .round_en    (round_en),
        .w_load      (w_load),
        .init_hash   (init_hash),
        .final_add   (final_add),
        .done        (done)
`ifdef SHA256_CTRL_STALL_EN
        ,
        .hold        (hold)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered K lookup owned by the parent in the real system: one cycle of latency.
    always_ff @(posedge clk) begin
        k_out <= K_TAB[round];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"},     32'(ready),     32'd1);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " round"},     32'(round),     32'd0);
        check({tag, " cur_round"}, 32'(cur_round), 32'd0);
        check({tag, " round_en"},  32'(round_en),  32'd0);
        check({tag, " w_load"},    32'(w_load),    32'd0);
        check({tag, " init_hash"}, 32'(init_hash), 32'd0);
        check({tag, " final_add"}, 32'(final_add), 32'd0);
        check({tag, " done"},      32'(done),      32'd0);
    endtask

    // Phase p: 1 = PRIME, 2..65 = rounds 0..63, 66 = FINAL, 67 = DONE. Called just after a posedge
    // with the DUT idle; returns just after the posedge that ends the DONE cycle.
    task automatic run_block(input logic first, input bit keep_start, input int prime_hold,
                             input int hold_at, input int hold_len, input bit hold_tail,
                             input int abort_at);
        int  p;
        int  ph;
        int  rh;
        bit  held;
        logic        e_en;
        logic        e_init;
        logic [31:0] e_round;
        string       t;
        start       = 1'b1;
        first_block = first;
        hold        = hold_tail;
        @(negedge clk);
        check("accept ready", 32'(ready), 32'd1);
        check("accept busy",  32'(busy),  32'd0);
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
        first_block = ~first;
        p  = 1;
        ph = 0;
        rh = 0;
        while (p <= 67) begin
            held = (p == 1 && ph < prime_hold) || (p == hold_at + 2 && rh < hold_len);
            hold = held || (hold_tail && p >= 66);
            @(negedge clk);
            t       = $sformatf("p%0d", p);
            e_en    = (p >= 2 && p <= 65 && !held);
            e_init  = (p == 1 && !held) ? first : 1'b0;
            e_round = 32'd0;
            if (p >= 2 && p <= 65) e_round = held ? 32'(p - 2) : 32'((p - 1) % 64);
            check({t, " ready"},     32'(ready),     32'd0);
            check({t, " busy"},      32'(busy),      32'd1);
            check({t, " round_en"},  32'(round_en),  32'(e_en));
            check({t, " init_hash"}, 32'(init_hash), 32'(e_init));
            check({t, " final_add"}, 32'(final_add), 32'(p == 66));
            check({t, " done"},      32'(done),      32'(p == 67));
            check({t, " round"},     32'(round),     e_round);
            check({t, " w_load"},    32'(w_load),    32'(e_en && (p - 2) < 16));
            if (e_en) begin
                check({t, " cur_round"}, 32'(cur_round), 32'(p - 2));
                check({t, " k_out"},     k_out,          K_TAB[p - 2]);
            end
            if (p == abort_at) begin
                #1 reset_n = 1'b0;
                #1 check_reset_outputs("abort");
                hold  = 1'b0;
                start = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (held) begin
                if (p == 1) ph++;
                else rh++;
            end else begin
                p++;
            end
        end
        hold = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        first_block = 1'b0;
        hold        = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single block with initial hash load, then a continuation block.
        run_block(1'b1, 1'b0, 0, 0, 0, 1'b0, -1);
        @(negedge clk);
        check("post1 ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        run_block(1'b0, 1'b0, 0, 0, 0, 1'b0, -1);
        repeat (2) @(posedge clk);
        #1;

        // Start held high: accepted back-to-back every 68 cycles, ignored while busy.
        run_block(1'b1, 1'b1, 0, 0, 0, 1'b0, -1);
        run_block(1'b0, 1'b1, 0, 0, 0, 1'b0, -1);
        run_block(1'b1, 1'b1, 0, 0, 0, 1'b0, -1);
        start = 1'b0;
        @(negedge clk);
        check("b2b idle ready", 32'(ready), 32'd1);
        @(negedge clk);
        check("b2b idle busy",  32'(busy),  32'd0);
        @(posedge clk);
        #1;

        // Reset asserted at cur_round 30 abandons the block.
        run_block(1'b1, 1'b0, 0, 0, 0, 1'b0, 32);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post-abort%0d done", i),  32'(done),  32'd0);
            check($sformatf("post-abort%0d ready", i), 32'(ready), 32'd1);
        end
        @(posedge clk);
        #1;
        run_block(1'b0, 1'b0, 0, 0, 0, 1'b0, -1);
        @(posedge clk);
        #1;

`ifdef SHA256_CTRL_STALL_EN
        // One held cycle in PRIME plus three at round 10: done lands at T+71.
        run_block(1'b1, 1'b0, 1, 10, 3, 1'b0, -1);
        @(posedge clk);
        #1;
        // Hold during IDLE, FINAL and DONE has no effect.
        run_block(1'b0, 1'b0, 0, 0, 0, 1'b1, -1);
        hold = 1'b1;
        @(negedge clk);
        check("idle hold ready", 32'(ready), 32'd1);
        hold = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
